// File: rtl/sm_cond_control_if.sv
// Signal bundle between the ARM-subset control unit and the datapath / data memory it steers.
// The control unit uses the master side. The datapath or testbench uses the slave side.
interface sm_cond_control_if;
    logic [31:0] instr;
    logic [3:0]  alu_flags;
    logic        mem_ack;
    logic [1:0]  RegSrc;
    logic        RegWrite;
    logic [1:0]  ImmSrc;
    logic        ALUSrc;
    logic [1:0]  ALUControl;
    logic        MemtoReg;
    logic        PCSrc;
    logic        writeData3Src;
    logic        srcASrc;
    logic        pc_en;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  flags_q;
    logic        mem_err;

    modport master (
        input  instr, alu_flags, mem_ack,
        output RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemtoReg, PCSrc,
               writeData3Src, srcASrc, pc_en, mem_req, mem_we, flags_q, mem_err
    );

    modport slave (
        output instr, alu_flags, mem_ack,
        input  RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemtoReg, PCSrc,
               writeData3Src, srcASrc, pc_en, mem_req, mem_we, flags_q, mem_err
    );
endinterface

// File: rtl/sm_cond_control.sv
// Control unit for the single-cycle ARM-subset datapath: decode, NZCV + condition codes,
// and a RUN/WAIT sequencer that stalls the PC while a data-memory access is outstanding.
module sm_cond_control #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    sm_cond_control_if.master bus
);
    typedef enum logic {RUN, WAIT} state_t;

    state_t           r_state, w_nextState;
    logic [CNT_W-1:0] r_cnt, w_nextCnt;
    logic [3:0]       r_flags;
    logic             r_memErr;

    logic [1:0] w_op;
    logic [3:0] w_cond, w_cmd, w_rd;
    logic       w_s, w_i, w_u, w_l, w_link;
    logic       w_n, w_z, w_c, w_v;
    logic       w_condPass, w_timeout, w_unused;

    logic [1:0] w_regSrc, w_immSrc, w_aluCtl;
    logic       w_aluSrc, w_memToReg, w_wd3Src, w_srcASrc;
    logic       w_dpWrite, w_dpFlagsAll, w_dpFlagsNz;

    logic       w_regWrite, w_pcSrc, w_pcEn, w_memReq, w_memWe;
    logic       w_setErr, w_flagsAllWe, w_flagsNzWe;

    assign w_op   = bus.instr[27:26];
    assign w_cond = bus.instr[31:28];
    assign w_cmd  = bus.instr[24:21];
    assign w_s    = bus.instr[20];
    assign w_i    = bus.instr[25];
    assign w_rd   = bus.instr[15:12];
    assign w_u    = bus.instr[23];
    assign w_l    = bus.instr[20];
    assign w_link = bus.instr[24];
    assign w_unused = ^{bus.instr[19:16], bus.instr[11:0]};

    assign {w_n, w_z, w_c, w_v} = r_flags;

    always_comb begin
        w_condPass = 1'b0;
        case (w_cond)
            4'b0000: w_condPass = w_z;
            4'b0001: w_condPass = !w_z;
            4'b0010: w_condPass = w_c;
            4'b0011: w_condPass = !w_c;
            4'b0100: w_condPass = w_n;
            4'b0101: w_condPass = !w_n;
            4'b0110: w_condPass = w_v;
            4'b0111: w_condPass = !w_v;
            4'b1000: w_condPass = w_c && !w_z;
            4'b1001: w_condPass = !w_c || w_z;
            4'b1010: w_condPass = (w_n == w_v);
            4'b1011: w_condPass = (w_n != w_v);
            4'b1100: w_condPass = !w_z && (w_n == w_v);
            4'b1101: w_condPass = w_z || (w_n != w_v);
            4'b1110: w_condPass = 1'b1;
            default: w_condPass = 1'b0;
        endcase
    end

    // The datapath selects depend only on the instruction. The condition gates just the side effects.
    always_comb begin
        w_regSrc     = 2'b00;
        w_immSrc     = 2'b00;
        w_aluSrc     = 1'b0;
        w_aluCtl     = 2'b00;
        w_memToReg   = 1'b0;
        w_wd3Src     = 1'b0;
        w_srcASrc    = 1'b0;
        w_dpWrite    = 1'b0;
        w_dpFlagsAll = 1'b0;
        w_dpFlagsNz  = 1'b0;
        case (w_op)
            2'b00: begin
                w_aluSrc = w_i;
                case (w_cmd)
                    4'b0100: begin w_dpWrite = 1'b1; w_dpFlagsAll = w_s; end
                    4'b0010: begin w_aluCtl = 2'b01; w_dpWrite = 1'b1; w_dpFlagsAll = w_s; end
                    4'b0000: begin w_aluCtl = 2'b10; w_dpWrite = 1'b1; w_dpFlagsNz = w_s; end
                    4'b1100: begin w_aluCtl = 2'b11; w_dpWrite = 1'b1; w_dpFlagsNz = w_s; end
                    4'b1010: begin w_aluCtl = 2'b01; w_dpFlagsAll = 1'b1; end
                    4'b1101: begin w_srcASrc = 1'b1; w_dpWrite = 1'b1; w_dpFlagsNz = w_s; end
                    default: ;
                endcase
            end
            2'b01: begin
                w_immSrc    = 2'b01;
                w_aluSrc    = 1'b1;
                w_aluCtl    = w_u ? 2'b00 : 2'b01;
                w_memToReg  = w_l;
                w_regSrc[1] = !w_l;
            end
            2'b10: begin
                w_regSrc[0] = 1'b1;
                w_immSrc    = 2'b10;
                w_aluSrc    = 1'b1;
                w_wd3Src    = w_link;
            end
            default: ;
        endcase
    end

    assign w_timeout = (MEM_TIMEOUT != 0) && (r_cnt == CNT_W'(MEM_TIMEOUT));

    // In WAIT the stalled PC holds the same load/store, so the decode fields still describe it.
    always_comb begin
        w_nextState  = r_state;
        w_nextCnt    = r_cnt;
        w_regWrite   = 1'b0;
        w_pcSrc      = 1'b0;
        w_pcEn       = 1'b1;
        w_memReq     = 1'b0;
        w_memWe      = 1'b0;
        w_setErr     = 1'b0;
        w_flagsAllWe = 1'b0;
        w_flagsNzWe  = 1'b0;
        case (r_state)
            RUN: begin
                if (w_condPass) begin
                    case (w_op)
                        2'b00: begin
                            w_regWrite   = w_dpWrite;
                            w_pcSrc      = w_dpWrite && (w_rd == 4'd15);
                            w_flagsAllWe = w_dpFlagsAll;
                            w_flagsNzWe  = w_dpFlagsNz;
                        end
                        2'b01: begin
                            w_memReq = 1'b1;
                            w_memWe  = !w_l;
                            if (bus.mem_ack) begin
                                w_regWrite = w_l;
                                w_pcSrc    = w_l && (w_rd == 4'd15);
                            end else begin
                                w_pcEn      = 1'b0;
                                w_nextState = WAIT;
                                w_nextCnt   = CNT_W'(1);
                            end
                        end
                        2'b10: begin
                            w_pcSrc    = 1'b1;
                            w_regWrite = w_link;
                        end
                        default: ;
                    endcase
                end
            end
            WAIT: begin
                if (bus.mem_ack) begin
                    w_memReq    = 1'b1;
                    w_memWe     = !w_l;
                    w_regWrite  = w_l;
                    w_pcSrc     = w_l && (w_rd == 4'd15);
                    w_nextState = RUN;
                    w_nextCnt   = '0;
                end else if (w_timeout) begin
                    w_setErr    = 1'b1;
                    w_nextState = RUN;
                    w_nextCnt   = '0;
                end else begin
                    w_memReq  = 1'b1;
                    w_memWe   = !w_l;
                    w_pcEn    = 1'b0;
                    w_nextCnt = r_cnt + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
        end
    end

    // Logical ops and MOV leave C and V untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags  <= 4'b0000;
            r_memErr <= 1'b0;
        end else begin
            if (w_flagsAllWe)
                r_flags <= bus.alu_flags;
            else if (w_flagsNzWe)
                r_flags <= {bus.alu_flags[3:2], r_flags[1:0]};
            if (w_setErr)
                r_memErr <= 1'b1;
        end
    end

    assign bus.RegSrc        = w_regSrc;
    assign bus.ImmSrc        = w_immSrc;
    assign bus.ALUSrc        = w_aluSrc;
    assign bus.ALUControl    = w_aluCtl;
    assign bus.MemtoReg      = w_memToReg;
    assign bus.writeData3Src = w_wd3Src;
    assign bus.srcASrc       = w_srcASrc;
    assign bus.RegWrite      = w_regWrite && rst_n;
    assign bus.PCSrc         = w_pcSrc && rst_n;
    assign bus.pc_en         = w_pcEn && rst_n;
    assign bus.mem_req       = w_memReq && rst_n;
    assign bus.mem_we        = w_memWe && rst_n;
    assign bus.flags_q       = r_flags;
    assign bus.mem_err       = r_memErr;
endmodule

// File: tb/tb_sm_cond_control.sv
// Bench for sm_cond_control: directed vector table, hand-written stall/timeout/reset sequences,
// and random instruction streams compared against an instruction-level reference model.
module tb_sm_cond_control;
    localparam int TIMEOUT = 4;
    localparam logic [31:0] NOP_INSTR = 32'hEE000000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sm_cond_control_if bus();

    sm_cond_control #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int passes = 0;

    logic [14:0] actOut;
    assign actOut = {bus.RegSrc, bus.RegWrite, bus.ImmSrc, bus.ALUSrc, bus.ALUControl, bus.MemtoReg,
                     bus.PCSrc, bus.writeData3Src, bus.srcASrc, bus.pc_en, bus.mem_req, bus.mem_we};

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  aluF;
        logic        ack;
        logic [14:0] expOut;
        logic [3:0]  expFlags;
    } vec_t;
    vec_t vecs[14];

    logic [3:0] mFlags;
    bit         mErr;
    bit         mBusy;
    int         mWaited;

    function automatic logic [14:0] packOut(logic [1:0] regSrc, logic rw, logic [1:0] imm, logic aluSrc,
                                            logic [1:0] ctl, logic m2r, logic pcs, logic wd3, logic srcA,
                                            logic pcEn, logic req, logic we);
        return {regSrc, rw, imm, aluSrc, ctl, m2r, pcs, wd3, srcA, pcEn, req, we};
    endfunction

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    endtask

    task automatic applyStimulus(logic [31:0] instr, logic [3:0] aluF, logic ack);
        @(negedge clk);
        bus.instr     = instr;
        bus.alu_flags = aluF;
        bus.mem_ack   = ack;
        #1;
    endtask

    task automatic resetDut();
        @(negedge clk);
        bus.instr   = NOP_INSTR;
        bus.mem_ack = 1'b0;
        rst_n       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mFlags = 4'b0000; mErr = 0; mBusy = 0; mWaited = 0;
    endtask

    // Even condition codes name a base predicate. The odd code after each one is its negation, and AL/NV fit the same pattern.
    function automatic bit condHolds(logic [3:0] c, logic [3:0] f);
        bit n, z, cf, v, base;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic logic [14:0] modelOut(logic [31:0] ins, logic ack);
        logic [1:0] op, ctl, imm;
        logic [3:0] cmd;
        bit pass, dpWrites, memActive, gaveUp, req, rw, pcs, aluSrc;
        op   = ins[27:26];
        cmd  = ins[24:21];
        pass = condHolds(ins[31:28], mFlags);
        imm  = (op == 2'd1) ? 2'd1 : (op == 2'd2) ? 2'd2 : 2'd0;
        aluSrc = (op == 2'd0) ? ins[25] : (op == 2'd1 || op == 2'd2);
        if (op == 2'd1)      ctl = ins[23] ? 2'd0 : 2'd1;
        else if (op == 2'd0) ctl = (cmd == 4'b0010 || cmd == 4'b1010) ? 2'd1 :
                                   (cmd == 4'b0000) ? 2'd2 : (cmd == 4'b1100) ? 2'd3 : 2'd0;
        else                 ctl = 2'd0;
        dpWrites  = (op == 2'd0) && (cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1101});
        memActive = mBusy || (op == 2'd1 && pass);
        gaveUp    = mBusy && !ack && (mWaited == TIMEOUT);
        req       = memActive && !gaveUp;
        rw  = (pass && !mBusy && dpWrites) || (pass && op == 2'd2 && ins[24]) || (memActive && ack && ins[20]);
        pcs = (pass && op == 2'd2) || (rw && ins[15:12] == 4'd15 && op != 2'd2);
        return packOut({op == 2'd1 && !ins[20], op == 2'd2}, rw, imm, aluSrc, ctl,
                       op == 2'd1 && ins[20], pcs, op == 2'd2 && ins[24],
                       op == 2'd0 && cmd == 4'b1101, !memActive || ack || gaveUp, req, req && !ins[20]);
    endfunction

    task automatic modelAdvance(logic [31:0] ins, logic [3:0] aluF, logic ack);
        logic [1:0] op;
        logic [3:0] cmd;
        bit pass, memActive;
        op   = ins[27:26];
        cmd  = ins[24:21];
        pass = condHolds(ins[31:28], mFlags);
        if (op == 2'd0 && pass && !mBusy) begin
            if (cmd == 4'b1010 || (ins[20] && (cmd == 4'b0100 || cmd == 4'b0010)))
                mFlags = aluF;
            else if (ins[20] && cmd inside {4'b0000, 4'b1100, 4'b1101})
                mFlags[3:2] = aluF[3:2];
        end
        memActive = mBusy || (op == 2'd1 && pass);
        if (memActive) begin
            if (ack) begin
                mBusy = 0; mWaited = 0;
            end else if (mBusy && mWaited == TIMEOUT) begin
                mErr = 1; mBusy = 0; mWaited = 0;
            end else begin
                mBusy = 1; mWaited++;
            end
        end
    endtask

    function automatic logic [31:0] randInstr();
        logic [31:0] r;
        logic [3:0]  cmds[6];
        cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010, 4'b1101};
        r = $urandom;
        if ($urandom_range(1) == 1) r[24:21] = cmds[$urandom_range(5)];
        return r;
    endfunction

    initial begin
        logic [31:0] curInstr;
        logic [3:0]  aluF;
        logic        ack;

        bus.instr = 32'hE0921003; bus.alu_flags = 4'b0100; bus.mem_ack = 1'b1;
        rst_n = 1'b0;
        #1;
        checkOutput("reset gated outputs", 32'({bus.RegWrite, bus.PCSrc, bus.pc_en, bus.mem_req, bus.mem_we}), 32'd0);
        checkOutput("reset flags_q", 32'(bus.flags_q), 32'd0);
        checkOutput("reset mem_err", 32'(bus.mem_err), 32'd0);
        bus.instr = NOP_INSTR; bus.mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        vecs[0]  = '{32'hE0921003, 4'b0100, 1'b0, packOut(2'b00,1,2'b00,0,2'b00,0,0,0,0,1,0,0), 4'b0000};
        vecs[1]  = '{32'h1A000002, 4'b0000, 1'b0, packOut(2'b01,0,2'b10,1,2'b00,0,0,0,0,1,0,0), 4'b0100};
        vecs[2]  = '{32'h0A000002, 4'b0000, 1'b0, packOut(2'b01,0,2'b10,1,2'b00,0,1,0,0,1,0,0), 4'b0100};
        vecs[3]  = '{32'hEB000004, 4'b0000, 1'b0, packOut(2'b01,1,2'b10,1,2'b00,0,1,1,0,1,0,0), 4'b0100};
        vecs[4]  = '{32'hE081F002, 4'b1111, 1'b0, packOut(2'b00,1,2'b00,0,2'b00,0,1,0,0,1,0,0), 4'b0100};
        vecs[5]  = '{32'hE1510002, 4'b1001, 1'b0, packOut(2'b00,0,2'b00,0,2'b01,0,0,0,0,1,0,0), 4'b0100};
        vecs[6]  = '{32'hE0110002, 4'b0110, 1'b0, packOut(2'b00,1,2'b00,0,2'b10,0,0,0,0,1,0,0), 4'b1001};
        vecs[7]  = '{32'hE5954008, 4'b0000, 1'b1, packOut(2'b00,1,2'b01,1,2'b00,1,0,0,0,1,1,0), 4'b0101};
        vecs[8]  = '{32'hE5854008, 4'b0000, 1'b1, packOut(2'b10,0,2'b01,1,2'b00,0,0,0,0,1,1,1), 4'b0101};
        vecs[9]  = '{32'hF0821003, 4'b1111, 1'b0, packOut(2'b00,0,2'b00,0,2'b00,0,0,0,0,1,0,0), 4'b0101};
        vecs[10] = '{NOP_INSTR,    4'b1111, 1'b1, packOut(2'b00,0,2'b00,0,2'b00,0,0,0,0,1,0,0), 4'b0101};
        vecs[11] = '{32'hA3822001, 4'b1111, 1'b0, packOut(2'b00,0,2'b00,1,2'b11,0,0,0,0,1,0,0), 4'b0101};
        vecs[12] = '{32'hE3B03005, 4'b1010, 1'b0, packOut(2'b00,1,2'b00,1,2'b00,0,0,0,1,1,0,0), 4'b0101};
        vecs[13] = '{32'hE5154008, 4'b0000, 1'b1, packOut(2'b00,1,2'b01,1,2'b01,1,0,0,0,1,1,0), 4'b1001};

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].instr, vecs[i].aluF, vecs[i].ack);
            checkOutput($sformatf("vec%0d outputs", i), 32'(actOut), 32'(vecs[i].expOut));
            checkOutput($sformatf("vec%0d flags_q", i), 32'(bus.flags_q), 32'(vecs[i].expFlags));
        end

        // LDR acknowledged on its fourth cycle, then the FSM is back in RUN.
        for (int c = 1; c <= 3; c++) begin
            applyStimulus(32'hE5954008, 4'b0000, 1'b0);
            checkOutput($sformatf("ldr stall c%0d", c), 32'(actOut), 32'(packOut(2'b00,0,2'b01,1,2'b00,1,0,0,0,0,1,0)));
        end
        applyStimulus(32'hE5954008, 4'b0000, 1'b1);
        checkOutput("ldr ack commit", 32'(actOut), 32'(packOut(2'b00,1,2'b01,1,2'b00,1,0,0,0,1,1,0)));
        applyStimulus(NOP_INSTR, 4'b0000, 1'b0);
        checkOutput("ldr back in run", 32'(actOut), 32'(packOut(2'b00,0,2'b00,0,2'b00,0,0,0,0,1,0,0)));

        // STR that is never acknowledged is abandoned after TIMEOUT wait cycles.
        for (int c = 1; c <= 4; c++) begin
            applyStimulus(32'hE5854008, 4'b0000, 1'b0);
            checkOutput($sformatf("str wait c%0d", c), 32'(actOut), 32'(packOut(2'b10,0,2'b01,1,2'b00,0,0,0,0,0,1,1)));
        end
        applyStimulus(32'hE5854008, 4'b0000, 1'b0);
        checkOutput("str abort", 32'(actOut), 32'(packOut(2'b10,0,2'b01,1,2'b00,0,0,0,0,1,0,0)));
        applyStimulus(NOP_INSTR, 4'b0000, 1'b0);
        checkOutput("mem_err after abort", 32'(bus.mem_err), 32'd1);

        // Reset asserted while the LDR is waiting must drop the request immediately.
        applyStimulus(32'hE5954008, 4'b0000, 1'b0);
        applyStimulus(32'hE5954008, 4'b0000, 1'b0);
        checkOutput("ldr in wait", 32'(bus.mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("reset in wait gated", 32'({bus.RegWrite, bus.PCSrc, bus.pc_en, bus.mem_req, bus.mem_we}), 32'd0);
        checkOutput("reset in wait mem_err", 32'(bus.mem_err), 32'd0);
        bus.instr = NOP_INSTR;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(NOP_INSTR, 4'b0000, 1'b0);
        checkOutput("after reset run", 32'(actOut), 32'(packOut(2'b00,0,2'b00,0,2'b00,0,0,0,0,1,0,0)));
        checkOutput("after reset flags", 32'(bus.flags_q), 32'd0);

        // An ack in the timeout cycle wins over the timeout.
        for (int c = 1; c <= 4; c++) applyStimulus(32'hE5854008, 4'b0000, 1'b0);
        applyStimulus(32'hE5854008, 4'b0000, 1'b1);
        checkOutput("str ack at timeout", 32'(actOut), 32'(packOut(2'b10,0,2'b01,1,2'b00,0,0,0,0,1,1,1)));
        applyStimulus(NOP_INSTR, 4'b0000, 1'b0);
        checkOutput("no err on late ack", 32'(bus.mem_err), 32'd0);

        resetDut();
        curInstr = NOP_INSTR;
        for (int n = 0; n < 400; n++) begin
            if (!mBusy) curInstr = randInstr();
            aluF = 4'($urandom);
            ack  = ($urandom_range(3) == 0);
            applyStimulus(curInstr, aluF, ack);
            checkOutput($sformatf("rand%0d outputs", n), 32'(actOut), 32'(modelOut(curInstr, ack)));
            checkOutput($sformatf("rand%0d flags_q", n), 32'(bus.flags_q), 32'(mFlags));
            checkOutput($sformatf("rand%0d mem_err", n), 32'(bus.mem_err), 32'(mErr));
            modelAdvance(curInstr, aluF, ack);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
